trigger_window_sched: RTL and testbench
=======================================

# trigger_window_sched

Schedules trigger-matching search windows for the TDC readout path. The block queues incoming trigger time stamps, which are coarse bunch-counter values, in a small FIFO. For each trigger it sequences a single shared rollover-aware adder over two cycles to compute the window start and end on the wrapping coarse-time axis. It presents each window to the matching logic with a valid/ready handshake and sits between the trigger interface and the trigger-matching engine.

## Interface
- `WIDTH`, 12: coarse time, offset, width and rollover bit width.
- `DEPTH`, 4: trigger FIFO depth, a power of two, at least 2.
- `ID_WIDTH`, 12: event ID width.

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: trigger acceptance enable.
- `trig_valid`  in  1: trigger strobe, one trigger per cycle when high.
- `trig_time`  in  WIDTH: coarse time of the trigger; must be <= `rollover`.
- `search_offset`  in  WIDTH: start distance from the trigger time; must be <= `rollover`.
- `window_width`  in  WIDTH: end distance from the start; must be <= `rollover`.
- `rollover`  in  WIDTH: maximum coarse count; the time axis is 0..`rollover`.
- `win_valid`  out  1: window output valid.
- `win_ready`  in  1: the matching engine accepts the window.
- `win_start`  out  WIDTH: window start.
- `win_end`  out  WIDTH: window end.
- `win_evt_id`  out  ID_WIDTH: event ID of the presented window.
- `fifo_full`  out  1: FIFO holds `DEPTH` entries.
- `trig_lost`  out  1: sticky flag, set when a trigger is dropped.
- `lost_cnt`  out  8: saturating count of dropped triggers.
- `lost_clr`  in  1: synchronous clear of `trig_lost` and `lost_cnt`.

## Operation
- **Rollover add.** The block contains one shared adder implementing the rollover add ra(a,b):
  - if (`rollover` − a) >= b, the result is a + b;
  - otherwise the result is a + b − `rollover` − 1.
  - All terms are WIDTH bits; the result is always in 0..`rollover` provided the inputs are in range.
- **Accept.** On a clock edge where `trig_valid`=1 and `enable`=1, the trigger is accepted when the FIFO is not full, or when it is full but a pop happens on the same edge.
  - An accepted trigger pushes {`trig_time`, `evt_cnt`} and increments `evt_cnt`.
  - `evt_cnt` wraps from 2^ID_WIDTH−1 to 0 and ignores `rollover`.
- **Drop.** A trigger that arrives while the FIFO is full and no pop occurs is dropped:
  - `trig_lost` is set to 1;
  - `lost_cnt` increments and saturates at 255;
  - `evt_cnt` is not incremented.
- **Ignore.** When `enable`=0, triggers are ignored without counting as lost. Work already queued or in flight still completes.
- **Clear priority.** `lost_clr` has priority over a drop on the same edge; the result is a cleared flag and a count of 0.
- **FSM states:** IDLE, START, END, PRESENT.
  - IDLE → START when the FIFO is non-empty. This edge pops the head into `work_time` and `work_id`.
  - START → END. This edge registers `win_start` = ra(`work_time`, `search_offset`).
  - END → PRESENT. This edge registers `win_end` = ra(`win_start`, `window_width`) and sets `win_evt_id` = `work_id`.
  - PRESENT: `win_valid`=1. The state holds, with all window outputs stable, until `win_valid`&`win_ready`.
  - On the transfer edge: if the FIFO is non-empty, pop and go to START; otherwise go to IDLE.
- **Adder sharing.** The adder inputs are multiplexed: (`work_time`, `search_offset`) in START and (`win_start`, `window_width`) in END.
- **Configuration stability.** `search_offset`, `window_width` and `rollover` must be static while the FSM is not in IDLE. They are not registered.

## Timing
- **Reset values.** All outputs are 0 on reset:
  - `win_valid`, `win_start`, `win_end`, `win_evt_id`;
  - `fifo_full`, `trig_lost`, `lost_cnt`.
- **Reset internals.** The FSM returns to IDLE, the FIFO empties and `evt_cnt` returns to 0. A reset during PRESENT discards the window with no handshake.
- **Latency.** A trigger accepted at edge E0 with the FSM idle produces `win_valid`=1 after edge E3.
- **Back-to-back throughput.** The next queued window appears 2 edges after a transfer edge. Sustained throughput is one window per 3 cycles when `win_ready`=1.
- **Push and pop.**
  - A simultaneous push and pop on the same edge leaves the FIFO count unchanged.
  - A pop from empty never occurs.
  - `fifo_full` is registered and updates on the same edge as the count.
- **Handshake.**
  - `win_valid` never deasserts without a transfer, except on reset.
  - `win_ready` may be high before `win_valid`.
  - `win_valid` drops after a transfer edge.

## Test plan
- **Basic window.** `rollover`=3563, `search_offset`=10, `window_width`=20, trigger at 100 on E0 → after E3, `win_start`=110, `win_end`=130, `win_evt_id`=0.
- **Wrap on start.** Trigger at 3560, offset 10 → `win_start`=6, `win_end`=26. Edge case: trigger at 3553, offset 10 → `win_start`=3563, no wrap.
- **Wrap on end.** Trigger at 3500, offset 50, width 30 → `win_start`=3550, `win_end`=16.
- **Overflow.** `win_ready` held 0, 6 triggers on E0..E5 → 5 accepted, 6th dropped, `trig_lost`=1, `lost_cnt`=1, `fifo_full`=1. Then release `win_ready` → event IDs 0,1,2,3,4 out in order, one window per 3 cycles.
- **Full with same-edge pop.** FIFO full, `win_ready`=1 at PRESENT, trigger arrives on the transfer edge → trigger accepted, no loss. `lost_clr` pulsed → `trig_lost`=0, `lost_cnt`=0.
- **Reset mid-operation.** `rst_n` asserted low during END with 2 entries queued → all outputs 0 immediately. After release, a new trigger yields `win_evt_id`=0 after E3.

Source files
------------

// File: rtl/trigger_window_sched_if.sv
// Window handshake bus between the trigger window scheduler and the matching engine.
interface trigger_window_sched_if #(
  parameter int WIDTH    = 12,
  parameter int ID_WIDTH = 12
);
  logic                win_valid;
  logic                win_ready;
  logic [WIDTH-1:0]    win_start;
  logic [WIDTH-1:0]    win_end;
  logic [ID_WIDTH-1:0] win_evt_id;

  modport master (
    output win_valid, win_start, win_end, win_evt_id,
    input  win_ready
  );

  modport slave (
    input  win_valid, win_start, win_end, win_evt_id,
    output win_ready
  );
endinterface

// File: rtl/trigger_window_sched.sv
// Queues trigger time stamps and computes rollover-aware search windows
// with one shared adder, presenting each window over a valid/ready bus.
//
// state   | meaning
// IDLE    | no work; pops the FIFO head when one is queued
// START   | adder computes window start from the trigger time
// END     | adder computes window end from the registered start
// PRESENT | window held on the bus until accepted
module trigger_window_sched #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trig_valid,
  input  logic [WIDTH-1:0]     trig_time,
  input  logic [WIDTH-1:0]     search_offset,
  input  logic [WIDTH-1:0]     window_width,
  input  logic [WIDTH-1:0]     rollover,
  trigger_window_sched_if.master win,
  output logic                 fifo_full,
  output logic                 trig_lost,
  output logic [7:0]           lost_cnt,
  input  logic                 lost_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_END, S_PRESENT} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mem_time_q [DEPTH];
  logic [WIDTH-1:0]    mem_time_d [DEPTH];
  logic [ID_WIDTH-1:0] mem_id_q   [DEPTH];
  logic [ID_WIDTH-1:0] mem_id_d   [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fifo_full_q, fifo_full_d;
  logic [ID_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
  logic [WIDTH-1:0]    work_time_q, work_time_d;
  logic [ID_WIDTH-1:0] work_id_q, work_id_d;
  logic                win_valid_q, win_valid_d;
  logic [WIDTH-1:0]    win_start_q, win_start_d;
  logic [WIDTH-1:0]    win_end_q, win_end_d;
  logic [ID_WIDTH-1:0] win_evt_id_q, win_evt_id_d;
  logic                trig_lost_q, trig_lost_d;
  logic [7:0]          lost_cnt_q, lost_cnt_d;

  logic             fifo_empty, xfer, pop, push_req, push, drop;
  logic [WIDTH-1:0] add_a, add_b, add_sum, add_res, headroom;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    xfer       = (state_q == S_PRESENT) && win.win_ready;
    pop        = !fifo_empty && ((state_q == S_IDLE) || xfer);
    push_req   = trig_valid && enable;
    // a full FIFO still takes a trigger when the head leaves on the same edge
    push       = push_req && (!fifo_full_q || pop);
    drop       = push_req && fifo_full_q && !pop;

    add_a    = (state_q == S_END) ? win_start_q  : work_time_q;
    add_b    = (state_q == S_END) ? window_width : search_offset;
    headroom = rollover - add_a;
    add_sum  = add_a + add_b;
    add_res  = (headroom >= add_b) ? add_sum : add_sum - rollover - WIDTH'(1);

    mem_time_d   = mem_time_q;
    mem_id_d     = mem_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    evt_cnt_d    = evt_cnt_q;
    work_time_d  = work_time_q;
    work_id_d    = work_id_q;
    state_d      = state_q;
    win_start_d  = win_start_q;
    win_end_d    = win_end_q;
    win_evt_id_d = win_evt_id_q;
    trig_lost_d  = trig_lost_q;
    lost_cnt_d   = lost_cnt_q;

    if (push) begin
      mem_time_d[wr_ptr_q] = trig_time;
      mem_id_d[wr_ptr_q]   = evt_cnt_q;
      wr_ptr_d             = wr_ptr_q + AW'(1);
      evt_cnt_d            = evt_cnt_q + ID_WIDTH'(1);
    end
    if (pop) begin
      work_time_d = mem_time_q[rd_ptr_q];
      work_id_d   = mem_id_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    fifo_full_d = (cnt_d == CW'(DEPTH));

    case (state_q)
      S_IDLE:    if (pop) state_d = S_START;
      S_START: begin
        win_start_d = add_res;
        state_d     = S_END;
      end
      S_END: begin
        win_end_d    = add_res;
        win_evt_id_d = work_id_q;
        state_d      = S_PRESENT;
      end
      S_PRESENT: if (xfer) state_d = pop ? S_START : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    win_valid_d = (state_d == S_PRESENT);

    if (lost_clr) begin
      trig_lost_d = 1'b0;
      lost_cnt_d  = 8'd0;
    end else if (drop) begin
      trig_lost_d = 1'b1;
      if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_time_q   <= '{default: '0};
      mem_id_q     <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      fifo_full_q  <= 1'b0;
      evt_cnt_q    <= '0;
      work_time_q  <= '0;
      work_id_q    <= '0;
      win_valid_q  <= 1'b0;
      win_start_q  <= '0;
      win_end_q    <= '0;
      win_evt_id_q <= '0;
      trig_lost_q  <= 1'b0;
      lost_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      mem_time_q   <= mem_time_d;
      mem_id_q     <= mem_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fifo_full_q  <= fifo_full_d;
      evt_cnt_q    <= evt_cnt_d;
      work_time_q  <= work_time_d;
      work_id_q    <= work_id_d;
      win_valid_q  <= win_valid_d;
      win_start_q  <= win_start_d;
      win_end_q    <= win_end_d;
      win_evt_id_q <= win_evt_id_d;
      trig_lost_q  <= trig_lost_d;
      lost_cnt_q   <= lost_cnt_d;
    end
  end

  assign win.win_valid  = win_valid_q;
  assign win.win_start  = win_start_q;
  assign win.win_end    = win_end_q;
  assign win.win_evt_id = win_evt_id_q;
  assign fifo_full      = fifo_full_q;
  assign trig_lost      = trig_lost_q;
  assign lost_cnt       = lost_cnt_q;
endmodule

// File: tb/tb_trigger_window_sched.sv
// Randomized and directed bench for trigger_window_sched with a queue-based
// reference model and a decoupled window scoreboard.
module tb_trigger_window_sched;
  localparam int WIDTH    = 12;
  localparam int DEPTH    = 4;
  localparam int ID_WIDTH = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             trig_valid = 1'b0;
  logic             lost_clr = 1'b0;
  logic [WIDTH-1:0] trig_time = '0;
  logic [WIDTH-1:0] search_offset = '0;
  logic [WIDTH-1:0] window_width = '0;
  logic [WIDTH-1:0] rollover = '0;
  logic             fifo_full, trig_lost;
  logic [7:0]       lost_cnt;

  trigger_window_sched_if #(.WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH)) win_if ();

  trigger_window_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .trig_valid    (trig_valid),
    .trig_time     (trig_time),
    .search_offset (search_offset),
    .window_width  (window_width),
    .rollover      (rollover),
    .win           (win_if),
    .fifo_full     (fifo_full),
    .trig_lost     (trig_lost),
    .lost_cnt      (lost_cnt),
    .lost_clr      (lost_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: occupancy of the trigger queue plus a worker that holds
  // one trigger for two edges of computation, then offers it until accepted.
  typedef struct {
    int s;
    int e;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt, m_phase, m_evt, m_lost_cnt;
  bit   m_busy, m_lost;
  bit   m_xfer, m_pop, m_req, m_push;
  int   m_s, m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_evt = 0; m_lost_cnt = 0;
      m_busy = 0; m_lost = 0;
      exp_q.delete();
    end else begin
      m_xfer = m_busy && (m_phase == 0) && win_if.win_ready;
      m_pop  = (m_cnt > 0) && (!m_busy || m_xfer);
      m_req  = trig_valid && enable;
      m_push = m_req && ((m_cnt < DEPTH) || m_pop);
      if (m_push) begin
        m_s = (int'(trig_time) + int'(search_offset)) % (int'(rollover) + 1);
        m_e = (m_s + int'(window_width)) % (int'(rollover) + 1);
        exp_q.push_back('{s: m_s, e: m_e, id: m_evt});
        m_evt = (m_evt + 1) % (1 << ID_WIDTH);
      end
      if (lost_clr) begin
        m_lost = 0; m_lost_cnt = 0;
      end else if (m_req && !m_push) begin
        m_lost = 1;
        if (m_lost_cnt < 255) m_lost_cnt++;
      end
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      if (m_pop) begin
        m_busy = 1; m_phase = 2;
      end else if (m_xfer) begin
        m_busy = 0;
      end else if (m_busy && m_phase > 0) begin
        m_phase--;
      end
    end
  end

  // Monitor: compares the bus and status flags every cycle, retires on transfer
  always @(negedge clk) begin
    if (rst_n) begin
      check("win_valid", int'(win_if.win_valid), int'(m_busy && m_phase == 0));
      check("fifo_full", int'(fifo_full), int'(m_cnt == DEPTH));
      check("trig_lost", int'(trig_lost), int'(m_lost));
      check("lost_cnt", int'(lost_cnt), m_lost_cnt);
      if (win_if.win_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          check("sb_start", int'(win_if.win_start), exp_q[0].s);
          check("sb_end", int'(win_if.win_end), exp_q[0].e);
          check("sb_id", int'(win_if.win_evt_id), exp_q[0].id);
          if (win_if.win_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int roll, input int off, input int w);
    rollover      = WIDTH'(roll);
    search_offset = WIDTH'(off);
    window_width  = WIDTH'(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_win_valid", int'(win_if.win_valid), 0);
    check("rst_win_start", int'(win_if.win_start), 0);
    check("rst_win_end", int'(win_if.win_end), 0);
    check("rst_win_evt_id", int'(win_if.win_evt_id), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_trig_lost", int'(trig_lost), 0);
    check("rst_lost_cnt", int'(lost_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic one_window(input string tag, input int t, input int es, input int ee, input int eid);
    trig_valid = 1'b1;
    trig_time  = WIDTH'(t);
    tick();
    trig_valid = 1'b0;
    tick();
    tick();
    check({tag, "_early"}, int'(win_if.win_valid), 0);
    tick();
    check({tag, "_valid"}, int'(win_if.win_valid), 1);
    check({tag, "_start"}, int'(win_if.win_start), es);
    check({tag, "_end"}, int'(win_if.win_end), ee);
    check({tag, "_id"}, int'(win_if.win_evt_id), eid);
    win_if.win_ready = 1'b1;
    tick();
    win_if.win_ready = 1'b0;
    check({tag, "_drop"}, int'(win_if.win_valid), 0);
  endtask

  task automatic drain();
    int n;
    trig_valid = 1'b0;
    lost_clr   = 1'b0;
    win_if.win_ready = 1'b1;
    n = 0;
    while ((m_cnt != 0 || m_busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_cnt", m_cnt + int'(m_busy), 0);
    win_if.win_ready = 1'b0;
  endtask

  initial begin
    int n;
    win_if.win_ready = 1'b0;
    enable = 1'b1;
    set_cfg(3563, 10, 20);
    do_reset();

    one_window("basic", 100, 110, 130, 0);
    one_window("wrap_start", 3560, 6, 26, 1);
    one_window("start_edge", 3553, 3563, 19, 2);
    set_cfg(3563, 50, 30);
    one_window("wrap_end", 3500, 3550, 16, 3);

    // overflow: six triggers against a stalled consumer
    set_cfg(3563, 10, 20);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      trig_valid = 1'b1;
      trig_time  = WIDTH'(200 + k);
      tick();
    end
    trig_valid = 1'b0;
    check("ovf_lost", int'(trig_lost), 1);
    check("ovf_lost_cnt", int'(lost_cnt), 1);
    check("ovf_full", int'(fifo_full), 1);
    win_if.win_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!win_if.win_valid && n < 10) begin
        tick();
        n++;
      end
      check("ovf_valid", int'(win_if.win_valid), 1);
      check("ovf_id", int'(win_if.win_evt_id), k);
      if (k > 0) check("ovf_gap", n + 1, 3);
      tick();
    end
    win_if.win_ready = 1'b0;
    drain();

    // full FIFO with a pop on the same edge as a new trigger
    for (int k = 0; k < 5; k++) begin
      trig_valid = 1'b1;
      trig_time  = WIDTH'(300 + k);
      tick();
    end
    check("full_pre", int'(fifo_full), 1);
    check("full_pre_valid", int'(win_if.win_valid), 1);
    trig_time = WIDTH'(305);
    win_if.win_ready = 1'b1;
    tick();
    win_if.win_ready = 1'b0;
    check("samepop_lost_cnt", int'(lost_cnt), 1);
    check("samepop_full", int'(fifo_full), 1);
    trig_time = WIDTH'(306);
    lost_clr  = 1'b1;
    tick();
    trig_valid = 1'b0;
    lost_clr   = 1'b0;
    check("clr_lost", int'(trig_lost), 0);
    check("clr_lost_cnt", int'(lost_cnt), 0);
    drain();

    // reset while the worker sits in END with two entries queued
    for (int k = 0; k < 3; k++) begin
      trig_valid = 1'b1;
      trig_time  = WIDTH'(400 + k);
      tick();
    end
    trig_valid = 1'b0;
    check("mid_queued", m_cnt, 2);
    do_reset();
    one_window("post_rst", 100, 110, 130, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (m_cnt == 0 && !m_busy && $urandom_range(7) == 0) begin
        rollover      = WIDTH'($urandom_range(4095, 16));
        search_offset = WIDTH'($urandom_range(int'(rollover)));
        window_width  = WIDTH'($urandom_range(int'(rollover)));
      end
      trig_valid       = ($urandom_range(1) == 1);
      enable           = ($urandom_range(4) != 0);
      win_if.win_ready = ($urandom_range(2) == 0);
      lost_clr         = ($urandom_range(40) == 0);
      trig_time        = WIDTH'($urandom_range(int'(rollover)));
      tick();
    end
    enable = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
